gpio_irq: RTL
=============

Name: gpio_irq

Overview:
- Parametrised next-generation GPIO peripheral on the SoC register bus.
- Provides per-pin direction, atomic set/clear/toggle of outputs, and a configurable-depth input synchroniser.
- Provides per-pin interrupt detection (level or edge, selectable polarity) with sticky write-1-to-clear status and a single aggregated interrupt line to the interrupt controller.

Parameters:
- WIDTH, 8, number of GPIO pins (1..32).
- SYNC_STAGES, 2, input synchroniser flop depth (>=2).
- RST_OUT, 0, reset value of DATA_OUT (WIDTH bits).

Ports:
- clk_i  in  1  system clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- addr_i  in  32  byte address; decode uses addr_i[7:2], addr_i[1:0] ignored.
- wdata_i  in  32  write data.
- we_i  in  1  write strobe, one cycle per access.
- re_i  in  1  read strobe, one cycle per access.
- rdata_o  out  32  read data, registered.
- gpio_i  in  WIDTH  asynchronous pin inputs.
- gpio_o  out  WIDTH  pin output values (= DATA_OUT).
- gpio_oe_o  out  WIDTH  pin output enables (= DIR, 1 = drive).
- irq_o  out  1  level interrupt = |(IRQ_STATUS & IRQ_EN).

Behaviour:
- Register map (offset, access, meaning):
  - 0x00 DATA_OUT rw.
  - 0x04 DIR rw.
  - 0x08 DATA_IN ro, synchronised pins.
  - 0x0C OUT_SET wo: DATA_OUT |= wdata.
  - 0x10 OUT_CLR wo: DATA_OUT &= ~wdata.
  - 0x14 OUT_TGL wo: DATA_OUT ^= wdata.
  - 0x18 IRQ_EN rw.
  - 0x1C IRQ_TYPE rw: 0 = level, 1 = edge.
  - 0x20 IRQ_POL rw: level 1 = high, 0 = low; edge 1 = rising, 0 = falling.
  - 0x24 IRQ_STATUS rw1c.
- Unmapped offsets: reads return 0, writes ignored. Write-only registers read 0.
- Bits [31:WIDTH] of every register: writes ignored, reads 0.
- Reset (async assert on rst_i, sync deassert handled upstream):
  - DATA_OUT = RST_OUT.
  - DIR, IRQ_EN, IRQ_TYPE, IRQ_POL, IRQ_STATUS = 0.
  - Synchroniser and edge-history flops = 0.
  - rdata_o = 0, irq_o = 0, gpio_oe_o = 0.
  - Reset mid-operation aborts any access and clears pending interrupts.
- Writes: take effect at the clk_i edge where we_i = 1. gpio_o and gpio_oe_o reflect the new value the following cycle. If we_i and re_i are both high, the write is performed and rdata_o returns the pre-write value.
- Reads: rdata_o is loaded at the edge where re_i = 1 (one-cycle latency) and holds its value until the next read.
- Input path: gpio_i passes through SYNC_STAGES flops to produce s. DATA_IN = s, visible SYNC_STAGES cycles after a stable pin change. p = s delayed by 1 cycle.
- Per-pin detect condition:
  - Level: s == IRQ_POL.
  - Edge rising: s & ~p.
  - Edge falling: ~s & p.
- Status update: the status bit is set on the edge after the condition is true, regardless of IRQ_EN (the enable masks irq_o only). Latency from a pin change to irq_o is SYNC_STAGES + 1 cycles.
- W1C: writing 1 to IRQ_STATUS clears the bit. If set and clear coincide in the same cycle, set wins. A level source that is still active therefore re-asserts the status immediately.
- Changing IRQ_TYPE or IRQ_POL does not clear status. Software clears status after reconfiguring.
- irq_o is combinational from the IRQ_STATUS and IRQ_EN flops, with no extra register stage.
- Output drive is independent of DIR. DATA_IN reflects the pad regardless of direction (loopback is visible).

Test Plan:
- Reset, WIDTH=8, RST_OUT=0 -> gpio_o=0x00, gpio_oe_o=0x00, irq_o=0; a read of 0x24 returns 0.
- Write DATA_OUT=0xA5, then OUT_SET=0x0A, OUT_CLR=0x81, OUT_TGL=0xFF -> gpio_o sequence 0xA5, 0xAF, 0x2E, 0xD1. Writing 0x1FF to DATA_OUT reads back 0xD1 → 0xFF with bits above WIDTH dropped: read returns 0x000000FF.
- gpio_i=0x3C held -> DATA_IN reads 0x3C; the change is first visible exactly SYNC_STAGES cycles after gpio_i changes. Read of unmapped offset 0x40 returns 0.
- IRQ_TYPE[0]=1, POL[0]=1, EN[0]=1; drive gpio_i[0] 0->1 -> STATUS[0]=1 and irq_o=1 SYNC_STAGES+1 cycles later. Write 0x1 to 0x24 -> irq_o=0 and stays 0 while the pin remains high. Falling edge with POL=1 -> no status.
- Level-low on pin 3 (TYPE=0, POL=0, EN=0x08), pin held low -> status re-asserts after W1C. Drive the pin high, then W1C -> irq_o=0. With EN=0, status still sets but irq_o stays 0.
- Assert rst_i mid-way through an edge-triggered pending interrupt and with DATA_OUT=0xFF -> all outputs return to reset values immediately without a clock. After release, no spurious edge is detected from the cleared history flops while gpio_i stays 0.

Source files
------------

// File: rtl/gpio_irq.sv
// GPIO peripheral with per-pin direction, atomic set/clear/toggle of the
// outputs, a configurable-depth input synchroniser, and per-pin level/edge
// interrupt detection. Interrupt status is sticky and write-1-to-clear.
// All interrupts are combined onto one active-high line.
//
// Bus handshake: we_i and re_i are single-cycle strobes with no backpressure.
// An access completes at the clk_i edge where its strobe is high. Read data
// appears on rdata_o after that edge and holds until the next read. When a
// read and a write happen together, the read returns the value from before
// the write.
module gpio_irq #(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RST_OUT     = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      addr_i,
    input  logic [31:0]      wdata_i,
    input  logic             we_i,
    input  logic             re_i,
    output logic [31:0]      rdata_o,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] gpio_oe_o,
    output logic             irq_o
);

    // Word index of each register (address bits [7:2])
    localparam logic [5:0] REG_DATA_OUT   = 6'h00;
    localparam logic [5:0] REG_DIR        = 6'h01;
    localparam logic [5:0] REG_DATA_IN    = 6'h02;
    localparam logic [5:0] REG_OUT_SET    = 6'h03;
    localparam logic [5:0] REG_OUT_CLR    = 6'h04;
    localparam logic [5:0] REG_OUT_TGL    = 6'h05;
    localparam logic [5:0] REG_IRQ_EN     = 6'h06;
    localparam logic [5:0] REG_IRQ_TYPE   = 6'h07;
    localparam logic [5:0] REG_IRQ_POL    = 6'h08;
    localparam logic [5:0] REG_IRQ_STATUS = 6'h09;

    logic [WIDTH-1:0] data_out_q,   data_out_d;
    logic [WIDTH-1:0] dir_q,        dir_d;
    logic [WIDTH-1:0] irq_en_q,     irq_en_d;
    logic [WIDTH-1:0] irq_type_q,   irq_type_d;
    logic [WIDTH-1:0] irq_pol_q,    irq_pol_d;
    logic [WIDTH-1:0] irq_status_q, irq_status_d;
    logic [WIDTH-1:0] prev_q,       prev_d;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [31:0]      rdata_q,      rdata_d;

    logic [5:0]       reg_idx;
    logic [WIDTH-1:0] wval;
    logic [WIDTH-1:0] s_in;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] level_hit;
    logic [WIDTH-1:0] detect;
    logic [WIDTH-1:0] w1c;
    logic [31:0]      rd_val;
    logic             unused_bits;

    assign reg_idx = addr_i[7:2];
    assign wval    = wdata_i[WIDTH-1:0];
    assign s_in    = sync_q[SYNC_STAGES-1];

    // Address byte-offset and upper bits take no part in decode.
    // Data bits above WIDTH are dropped on write.
    assign unused_bits = ^{addr_i[31:8], addr_i[1:0], wdata_i};

    // Pin synchroniser chain and one-cycle history for edge detection
    always_comb begin
        sync_d[0] = gpio_i;
        for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d = s_in;
    end

    // Per-pin detect: polarity selects high/rising (1) or low/falling (0)
    always_comb begin
        edge_hit  = (irq_pol_q & s_in & ~prev_q) | (~irq_pol_q & ~s_in & prev_q);
        level_hit = ~(s_in ^ irq_pol_q);
        detect    = (irq_type_q & edge_hit) | (~irq_type_q & level_hit);
    end

    // Register writes. A set condition in the same cycle as a W1C wins.
    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        irq_en_d   = irq_en_q;
        irq_type_d = irq_type_q;
        irq_pol_d  = irq_pol_q;
        w1c        = '0;
        if (we_i) begin
            case (reg_idx)
                REG_DATA_OUT:   data_out_d = wval;
                REG_DIR:        dir_d      = wval;
                REG_OUT_SET:    data_out_d = data_out_q | wval;
                REG_OUT_CLR:    data_out_d = data_out_q & ~wval;
                REG_OUT_TGL:    data_out_d = data_out_q ^ wval;
                REG_IRQ_EN:     irq_en_d   = wval;
                REG_IRQ_TYPE:   irq_type_d = wval;
                REG_IRQ_POL:    irq_pol_d  = wval;
                REG_IRQ_STATUS: w1c        = wval;
                default:        ;
            endcase
        end
        irq_status_d = (irq_status_q & ~w1c) | detect;
    end

    // Read mux. Registers are zero-extended, and write-only or unmapped offsets read 0.
    always_comb begin
        rd_val = '0;
        case (reg_idx)
            REG_DATA_OUT:   rd_val[WIDTH-1:0] = data_out_q;
            REG_DIR:        rd_val[WIDTH-1:0] = dir_q;
            REG_DATA_IN:    rd_val[WIDTH-1:0] = s_in;
            REG_IRQ_EN:     rd_val[WIDTH-1:0] = irq_en_q;
            REG_IRQ_TYPE:   rd_val[WIDTH-1:0] = irq_type_q;
            REG_IRQ_POL:    rd_val[WIDTH-1:0] = irq_pol_q;
            REG_IRQ_STATUS: rd_val[WIDTH-1:0] = irq_status_q;
            default:        rd_val = '0;
        endcase
        rdata_d = re_i ? rd_val : rdata_q;
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_out_q   <= RST_OUT;
            dir_q        <= '0;
            irq_en_q     <= '0;
            irq_type_q   <= '0;
            irq_pol_q    <= '0;
            irq_status_q <= '0;
            prev_q       <= '0;
            rdata_q      <= '0;
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            data_out_q   <= data_out_d;
            dir_q        <= dir_d;
            irq_en_q     <= irq_en_d;
            irq_type_q   <= irq_type_d;
            irq_pol_q    <= irq_pol_d;
            irq_status_q <= irq_status_d;
            prev_q       <= prev_d;
            rdata_q      <= rdata_d;
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    assign rdata_o   = rdata_q;
    assign gpio_o    = data_out_q;
    assign gpio_oe_o = dir_q;
    assign irq_o     = |(irq_status_q & irq_en_q);

endmodule
